// File: rtl/shift_frame_controller_pkg.sv
// Shared FSM encoding and width helper for the serial frame controller.
// No logic; latency and backpressure are not applicable.
package shift_frame_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter width that never collapses to zero bits, even for a count of 1.
  function automatic int clog2_floor1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/shift_frame_controller_tick_divider.sv
// Shift tick divider: pulses tick once every CLK_DIV enabled cycles.
// Tick is combinational from div_cnt; clear has priority over enable.
module shift_tick_divider
  import shift_frame_controller_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              W    = clog2_floor1(CLK_DIV);
  localparam logic [W-1:0]    LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt;

  assign tick = enable && (div_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_frame_controller.sv
// Full-duplex shift-frame sequencer: rx_valid rises SIZE*CLK_DIV cycles after accept.
// Holds the frame in DONE until rx_ready; start_ready is low while busy.
module shift_frame_controller
  import shift_frame_controller_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int CLK_DIV = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [SIZE-1:0] tx_data,
  input  logic            abort,
  input  logic            serial_in,
  output logic            serial_out,
  output logic            busy,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [SIZE-1:0] rx_data
);

  localparam int           BW       = $clog2(SIZE);
  localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

  state_t          state;
  logic [SIZE-1:0] shift_reg;
  logic [BW-1:0]   bit_cnt;
  logic            tick;
  logic            div_clear;
  logic            div_en;

  assign div_en    = (state == SHIFT);
  assign div_clear = (state != SHIFT) || abort;

  shift_tick_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .enable(div_en),
    .tick  (tick)
  );

  assign serial_out = (state == SHIFT) & shift_reg[SIZE-1];
  assign rx_data    = shift_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      rx_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            shift_reg   <= tx_data;
            bit_cnt     <= '0;
            state       <= SHIFT;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SHIFT, DONE: begin
          // abort outranks both the final tick and the consumer handshake
          if (abort) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            rx_valid    <= 1'b0;
          end else if (state == SHIFT) begin
            if (tick) begin
              shift_reg <= {shift_reg[SIZE-2:0], serial_in};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt  <= '0;
                state    <= DONE;
                rx_valid <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else if (rx_ready) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            rx_valid    <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          rx_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_frame_controller.sv
// Bench for shift_frame_controller: CLK_DIV=1 and CLK_DIV=3 instances against a frame-level model.
// Directed scenarios pin literal values; a random phase exercises abort/backpressure.
module tb_shift_frame_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [1:0]      sv, ab, rr, sidrv, loop;
  logic [1:0][7:0] tx;
  wire  [1:0]      sr, so, busy, rv, si;
  wire  [1:0][7:0] rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign si[0] = loop[0] ? so[0] : sidrv[0];
  assign si[1] = loop[1] ? so[1] : sidrv[1];

  shift_frame_controller #(.SIZE(8), .CLK_DIV(1)) u_dut0 (
    .clk(clk), .reset(reset), .start_valid(sv[0]), .start_ready(sr[0]),
    .tx_data(tx[0]), .abort(ab[0]), .serial_in(si[0]), .serial_out(so[0]),
    .busy(busy[0]), .rx_valid(rv[0]), .rx_ready(rr[0]), .rx_data(rd[0])
  );

  shift_frame_controller #(.SIZE(8), .CLK_DIV(3)) u_dut1 (
    .clk(clk), .reset(reset), .start_valid(sv[1]), .start_ready(sr[1]),
    .tx_data(tx[1]), .abort(ab[1]), .serial_in(si[1]), .serial_out(so[1]),
    .busy(busy[1]), .rx_valid(rv[1]), .rx_ready(rr[1]), .rx_data(rd[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Frame-level model: mode 0 idle, 1 shifting, 2 holding a completed frame.
  int         m_mode [2];
  int         m_e    [2];
  int         m_t    [2];
  logic [7:0] m_tx   [2];
  logic [7:0] m_cap  [2];
  logic [7:0] m_word [2];
  logic [7:0]  e_rd;
  logic [15:0] wide;
  logic        e_sr, e_so, e_busy, e_rv;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_mode[i] = 0;
        m_word[i] = 8'h00;
      end
      e_sr = 1'b0; e_so = 1'b0; e_busy = 1'b1; e_rv = 1'b0; e_rd = m_word[i];
      if (m_mode[i] == 0) begin
        e_sr = 1'b1; e_busy = 1'b0;
      end else if (m_mode[i] == 1) begin
        wide = ({8'h00, m_tx[i]} << m_t[i]) | {8'h00, m_cap[i]};
        e_rd = wide[7:0];
        e_so = m_tx[i][7 - m_t[i]];
      end else begin
        e_rv = 1'b1;
      end
      chk($sformatf("model%0d_start_ready", i), {31'd0, sr[i]}, {31'd0, e_sr});
      chk($sformatf("model%0d_serial_out", i), {31'd0, so[i]}, {31'd0, e_so});
      chk($sformatf("model%0d_busy", i), {31'd0, busy[i]}, {31'd0, e_busy});
      chk($sformatf("model%0d_rx_valid", i), {31'd0, rv[i]}, {31'd0, e_rv});
      chk($sformatf("model%0d_rx_data", i), {24'd0, rd[i]}, {24'd0, e_rd});

      if (reset) begin
        if (m_mode[i] == 0) begin
          if (sv[i]) begin
            m_mode[i] = 1; m_tx[i] = tx[i]; m_e[i] = 0; m_t[i] = 0; m_cap[i] = 8'h00;
          end
        end else if (ab[i]) begin
          m_mode[i] = 0;
          m_word[i] = 8'h00;
        end else if (m_mode[i] == 1) begin
          if (m_e[i] % div_of(i) == div_of(i) - 1) begin
            m_cap[i] = (m_cap[i] << 1) | {7'd0, si[i]};
            m_t[i]++;
            if (m_t[i] == 8) begin
              m_mode[i] = 2;
              m_word[i] = m_cap[i];
            end
          end
          m_e[i]++;
        end else if (rr[i]) begin
          m_mode[i] = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one word; returns one time unit after the accepting edge.
  task automatic send(input int i, input logic [7:0] w);
    int n = 0;
    while (!sr[i] && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout inst=%0d actual=not_ready required=ready", i);
    end
    sv[i] = 1'b1;
    tx[i] = w;
    step();
    sv[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    int acc[$];
    logic prev;
    int n;

    sv = '0; ab = '0; rr = '0; sidrv = '0; loop = '0; tx = '0;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("reset_start_ready", {31'd0, sr[i]}, 32'd1);
      chk("reset_busy", {31'd0, busy[i]}, 32'd0);
      chk("reset_rx_valid", {31'd0, rv[i]}, 32'd0);
      chk("reset_serial_out", {31'd0, so[i]}, 32'd0);
      chk("reset_rx_data", {24'd0, rd[i]}, 32'd0);
    end
    reset = 1'b1;
    step();

    // loopback of 0xA5 at CLK_DIV=1
    loop[0] = 1'b1;
    send(0, 8'hA5);
    repeat (7) step();
    chk("t1_rx_valid_early", {31'd0, rv[0]}, 32'd0);
    step();
    chk("t1_rx_valid", {31'd0, rv[0]}, 32'd1);
    chk("t1_rx_data", {24'd0, rd[0]}, 32'hA5);
    rr[0] = 1'b1; step(); rr[0] = 1'b0; loop[0] = 1'b0;

    // CLK_DIV=3, 0x80 with serial_in low
    send(1, 8'h80);
    for (int c = 0; c <= 24; c++) begin
      if (c <= 3) chk($sformatf("t2_serial_out_c%0d", c), {31'd0, so[1]}, (c < 3) ? 32'd1 : 32'd0);
      if (c == 23) chk("t2_rx_valid_early", {31'd0, rv[1]}, 32'd0);
      if (c == 24) begin
        chk("t2_rx_valid", {31'd0, rv[1]}, 32'd1);
        chk("t2_rx_data", {24'd0, rd[1]}, 32'h00);
      end
      if (c < 24) step();
    end
    rr[1] = 1'b1; step(); rr[1] = 1'b0;

    // driven serial pattern and held backpressure
    pat = 8'hB2;
    send(0, 8'h5A);
    for (int k = 0; k < 8; k++) begin
      sidrv[0] = pat[7 - k];
      step();
    end
    sidrv[0] = 1'b0;
    chk("t3_rx_valid", {31'd0, rv[0]}, 32'd1);
    chk("t3_rx_data", {24'd0, rd[0]}, 32'hB2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold_rx_valid", {31'd0, rv[0]}, 32'd1);
      chk("t3_hold_rx_data", {24'd0, rd[0]}, 32'hB2);
    end
    rr[0] = 1'b1; step(); rr[0] = 1'b0;

    // abort mid-frame, then a clean loopback frame
    loop[0] = 1'b1;
    send(0, 8'h5A);
    repeat (4) step();
    ab[0] = 1'b1; step(); ab[0] = 1'b0;
    chk("t4_start_ready", {31'd0, sr[0]}, 32'd1);
    chk("t4_rx_valid", {31'd0, rv[0]}, 32'd0);
    chk("t4_busy", {31'd0, busy[0]}, 32'd0);
    chk("t4_rx_data", {24'd0, rd[0]}, 32'h00);
    send(0, 8'h3C);
    repeat (8) step();
    chk("t4_next_rx_valid", {31'd0, rv[0]}, 32'd1);
    chk("t4_next_rx_data", {24'd0, rd[0]}, 32'h3C);
    rr[0] = 1'b1; step(); rr[0] = 1'b0;

    // asynchronous reset between edges
    send(0, 8'hC3);
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy[0]}, 32'd0);
    chk("t5_serial_out", {31'd0, so[0]}, 32'd0);
    chk("t5_start_ready", {31'd0, sr[0]}, 32'd1);
    chk("t5_rx_data", {24'd0, rd[0]}, 32'h00);
    step();
    reset = 1'b1;
    send(0, 8'h96);
    repeat (8) step();
    chk("t5_after_rx_valid", {31'd0, rv[0]}, 32'd1);
    chk("t5_after_rx_data", {24'd0, rd[0]}, 32'h96);
    rr[0] = 1'b1; step();

    // back-to-back frames with start_valid held
    tx[0] = 8'h77;
    sv[0] = 1'b1;
    prev = sr[0];
    for (int c = 0; c < 40; c++) begin
      step();
      if (prev && !sr[0]) acc.push_back(c);
      prev = sr[0];
    end
    sv[0] = 1'b0;
    chk("t6_accept_count_ge3", {31'd0, acc.size() >= 3}, 32'd1);
    for (int k = 1; k < acc.size(); k++)
      chk("t6_accept_period", acc[k] - acc[k-1], 32'd10);
    n = 0;
    while (!sr[0] && n < 40) begin
      step();
      n++;
    end
    chk("t6_drain", {31'd0, sr[0]}, 32'd1);
    rr[0] = 1'b0; loop[0] = 1'b0;

    // randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        sv[i]    = ($urandom_range(0, 3) == 0);
        tx[i]    = 8'($urandom);
        ab[i]    = ($urandom_range(0, 59) == 0);
        rr[i]    = ($urandom_range(0, 2) != 0);
        sidrv[i] = 1'($urandom_range(0, 1));
      end
      step();
    end
    sv = '0; ab = '0; rr = '0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
